// File: rtl/nes_pkg.sv
// Shared NES CPU-side definitions: DMA state encoding and fixed register addresses.
package nes_pkg;

   typedef enum logic [2:0] {IDLE, HALT, ALIGN, GET, PUT} dma_state_t;

   localparam logic [15:0] OAMDMA_REG  = 16'h4014;
   localparam logic [15:0] PPU_OAMDATA = 16'h2004;

endpackage

// File: rtl/oam_dma_controller_if.sv
// CPU-side bus seen by the OAM DMA controller: monitored CPU writes, memory read data, DMA outputs.
interface oam_dma_controller_if;

   logic [15:0] CPU_ADDR;
   logic [7:0]  CPU_DATA_IN;
   logic        CPU_wren;
   logic [7:0]  MEM_RDATA;
   logic        CPU_HALT;
   logic [15:0] DMA_ADDR;
   logic        DMA_rden;
   logic        DMA_wren;
   logic [7:0]  DMA_DATA_OUT;
   logic        DMA_BUSY;

   // master: the DMA controller, which owns the bus while halting the CPU
   modport master (
      input  CPU_ADDR, CPU_DATA_IN, CPU_wren, MEM_RDATA,
      output CPU_HALT, DMA_ADDR, DMA_rden, DMA_wren, DMA_DATA_OUT, DMA_BUSY
   );

   // slave: CPU core / memory map side
   modport slave (
      output CPU_ADDR, CPU_DATA_IN, CPU_wren, MEM_RDATA,
      input  CPU_HALT, DMA_ADDR, DMA_rden, DMA_wren, DMA_DATA_OUT, DMA_BUSY
   );

endinterface

// File: rtl/oam_dma_controller.sv
// Sprite OAM DMA: a $4014 write halts the CPU and copies page PP00..PPFF into OAMDATA.
// Define OAM_DMA_ABORT_EN to add the DMA_ABORT input.
module oam_dma_controller
   import nes_pkg::*;
#(
   parameter logic [15:0] TRIG_ADDR    = OAMDMA_REG,
   parameter logic [15:0] OAMDATA_ADDR = PPU_OAMDATA,
   parameter int          NUM_BYTES    = 256
) (
   input  logic CLK,
   input  logic RESET_N,
`ifdef OAM_DMA_ABORT_EN
   input  logic DMA_ABORT,
`endif
   oam_dma_controller_if.master bus
);

   localparam logic [7:0] LAST_IDX = 8'(NUM_BYTES - 1);

   dma_state_t state, state_n;
   logic [7:0] page, idx, data_q;
   logic       odd;
   logic       armed;
   logic       trig;
   logic       abort;

`ifdef OAM_DMA_ABORT_EN
   assign abort = DMA_ABORT;
`else
   assign abort = 1'b0;
`endif

   // armed keeps a trigger on the very edge that ends reset from being taken
   assign trig = armed && bus.CPU_wren && (bus.CPU_ADDR == TRIG_ADDR);

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (trig) state_n = HALT;
         HALT:    state_n = odd ? ALIGN : GET;
         ALIGN:   state_n = GET;
         GET:     state_n = PUT;
         PUT:     state_n = (idx == LAST_IDX) ? IDLE : GET;
         default: state_n = IDLE;
      endcase
      // a PUT being aborted still issues its write this cycle
      if (abort && state != IDLE) state_n = IDLE;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state  <= IDLE;
         odd    <= 1'b0;
         armed  <= 1'b0;
         page   <= '0;
         idx    <= '0;
         data_q <= '0;
      end else begin
         state <= state_n;
         odd   <= ~odd;
         armed <= 1'b1;
         if (state == IDLE && trig) begin
            page <= bus.CPU_DATA_IN;
            idx  <= '0;
         end
         if (state == GET) data_q <= bus.MEM_RDATA;
         if (state == PUT && state_n == GET) idx <= idx + 8'd1;
      end
   end

   // outputs decode straight from the state flop, so reset clears them without an edge
   assign bus.CPU_HALT     = (state != IDLE);
   assign bus.DMA_BUSY     = (state != IDLE);
   assign bus.DMA_rden     = (state == GET);
   assign bus.DMA_wren     = (state == PUT);
   assign bus.DMA_ADDR     = (state == GET) ? {page, idx} :
                             (state == PUT) ? OAMDATA_ADDR : 16'h0000;
   assign bus.DMA_DATA_OUT = (state == PUT) ? data_q : 8'h00;

endmodule
